// File: rtl/contador_param.sv
// contador_param: parametrised up/down/step/load counter.
// Q, RCO and n_wrap are all registered; RCO is a one-cycle pulse aligned with
// the cycle in which Q shows the wrapped value, and n_wrap counts those pulses,
// saturating at its maximum.
module contador_param #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned STEP      = 3,
  parameter int unsigned RESET_VAL = 0,
  parameter int unsigned WRAP_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic [1:0]        modo,
  input  logic [WIDTH-1:0]  D,
  output logic [WIDTH-1:0]  Q,
  output logic              RCO,
  output logic [WRAP_W-1:0] n_wrap
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_STEP = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  localparam logic [WIDTH:0]    ONE_X   = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]    STEP_X  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0]  RESET_Q = WIDTH'(RESET_VAL);
  localparam logic [WRAP_W-1:0] WRAP_INC = WRAP_W'(1);

  mode_t             mode;
  logic [WIDTH:0]    q_ext;
  logic [WIDTH:0]    sum_up;
  logic [WIDTH:0]    diff_down;
  logic [WIDTH:0]    diff_step;
  logic [WIDTH-1:0]  q_next;
  logic              rco_next;
  logic              wrap_sat;

  // Extended-width arithmetic: the top bit of each result is the carry/borrow
  // that becomes RCO, so no separate compares against Q are needed.
  always_comb begin
    mode      = mode_t'(modo);
    q_ext     = {1'b0, Q};
    sum_up    = q_ext + ONE_X;
    diff_down = q_ext - ONE_X;
    diff_step = q_ext - STEP_X;
  end

  // Next counter value and carry/borrow selection by mode.
  always_comb begin
    q_next   = Q;
    rco_next = 1'b0;
    if (enb) begin
      case (mode)
        MODE_UP: begin
          q_next   = sum_up[WIDTH-1:0];
          rco_next = sum_up[WIDTH];
        end
        MODE_DOWN: begin
          q_next   = diff_down[WIDTH-1:0];
          rco_next = diff_down[WIDTH];
        end
        MODE_STEP: begin
          q_next   = diff_step[WIDTH-1:0];
          rco_next = diff_step[WIDTH];
        end
        MODE_LOAD: begin
          q_next   = D;
          rco_next = 1'b0;
        end
      endcase
    end
  end

  assign wrap_sat = &n_wrap;

  // Counter, ripple-carry pulse and saturating wrap counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      Q      <= RESET_Q;
      RCO    <= 1'b0;
      n_wrap <= '0;
    end else begin
      Q   <= q_next;
      RCO <= rco_next;
      if (rco_next && !wrap_sat) begin
        n_wrap <= n_wrap + WRAP_INC;
      end
    end
  end

endmodule

// File: doc/contador_param.md
# contador_param

Parametrised up/down/step/load counter with a correctly timed, registered ripple-carry pulse and a saturating wrap counter. It is the general-width successor of the 4-bit four-mode counter and serves as the standard counting primitive for timers, dividers and cascaded counter chains. One clock domain; all state updates on the rising edge of `clk`.

## Interface

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32
- STEP, 3, decrement used in mode 2'b10; legal range 1..2^WIDTH-1
- RESET_VAL, 0, value loaded into Q by reset; must fit in WIDTH bits
- WRAP_W, 8, width of the wrap-event counter

Ports:
- clk  input  1  clock; rising edge active
- reset  input  1  synchronous, active-high reset
- enb  input  1  count enable; when low, Q holds and RCO is 0
- modo  input  2  mode select: 00 up by 1, 01 down by 1, 10 down by STEP, 11 parallel load
- D  input  WIDTH  parallel load data, used only in mode 11
- Q  output  WIDTH  registered counter value
- RCO  output  1  registered ripple-carry/borrow pulse; high for exactly the cycle in which Q shows the wrapped value
- n_wrap  output  WRAP_W  registered count of RCO pulses since reset; saturates

## Operation

- Reset (`reset`=1 at the clock edge) overrides everything:
  - Q <= RESET_VAL
  - RCO <= 0
  - n_wrap <= 0
- With `reset`=0 and `enb`=0: Q holds, RCO <= 0, n_wrap holds.
- With `reset`=0 and `enb`=1, by modo:
  - 00: Q <= (Q+1) mod 2^WIDTH. RCO <= 1 iff Q == all-ones before the edge.
  - 01: Q <= (Q-1) mod 2^WIDTH. RCO <= 1 iff Q == 0 before the edge.
  - 10: Q <= (Q-STEP) mod 2^WIDTH. RCO <= 1 iff Q < STEP before the edge (borrow). Q == STEP gives Q=0 with RCO=0.
  - 11: Q <= D. RCO <= 0. n_wrap is not affected.
- Arithmetic: computed at WIDTH+1 bits. The carry/borrow bit of that result drives RCO directly, with no look-ahead compares against Q. Q takes the low WIDTH bits.
- n_wrap increments by 1 on every edge at which RCO is set to 1. At 2^WRAP_W-1 it holds (saturates) and does not wrap.
- modo, D and enb are sampled only at the clock edge. A mode change takes effect on the same edge, with no pipeline.
- No combinational path from any input to any output.
- RCO is never high for two consecutive cycles unless a wrap occurs on each of those edges. Example: WIDTH=2, modo=01 continuously from Q=0 gives RCO=1 once every 4 cycles.

## Timing

- Latency: 1 cycle from sampled inputs to Q, RCO and n_wrap.
- RCO is aligned with the wrapped Q value:
  - Up count: Q=0 and RCO=1 appear in the same cycle.
  - Down count: Q=all-ones and RCO=1 appear in the same cycle.
- Reset mid-count: the next cycle shows Q=RESET_VAL, RCO=0, n_wrap=0, regardless of enb or modo.
- reset and enb both high: reset wins.
- enb deasserted in the cycle after a wrap: RCO drops to 0 and Q holds the wrapped value.
- Load of D=all-ones in mode 11 followed by mode 00: the first increment yields Q=0 with RCO=1.
- Cascading: the RCO of stage n drives the enb of stage n+1 (same modo 00/01). Stage n+1 therefore advances one cycle after stage n wraps. This fixed 1-cycle skew per stage is part of the contract.

## Test plan

- Reset then up count: WIDTH=4, RESET_VAL=0; reset 1 cycle; enb=1, modo=00 for 17 cycles. Required: Q goes 1..15, 0, 1. RCO=1 only in the cycle Q=0. n_wrap=1.
- Down-by-1 wrap: load D=4'h2 (modo=11), then modo=01 for 3 cycles. Required: Q goes 1, 0, 15. RCO=1 only with Q=15. No RCO in the load cycle.
- Down-by-STEP boundaries, STEP=3, one cycle of modo=10 from each start value:
  - Q=5: gives Q=2, RCO=0.
  - Q=3: gives Q=0, RCO=0.
  - Q=2: gives Q=15, RCO=1.
  - Q=0: gives Q=13, RCO=1.
- Enable and reset priority:
  - Counting up with enb dropped for 3 cycles: Q holds, RCO=0.
  - Assert reset together with enb=1, modo=11, D=4'h9: Q=RESET_VAL, RCO=0, n_wrap=0.
- Saturation: WRAP_W=2, WIDTH=2, modo=00 for 20 cycles. Required: n_wrap reaches 3 after the third wrap and stays 3. RCO keeps pulsing every 4th cycle.
- Two-stage cascade: WIDTH=4, stage1 enb=RCO of stage0, both modo=00, run 40 cycles. Required: stage1 Q=2 at cycle 33 and at every later cycle through cycle 40. Stage1 RCO=0 throughout.
